// File: rtl/control_sequencer.sv
// Microcoded control sequencer for the BasicCPU: fetch in T0/T1, opcode-specific
// execute in T2..T4, driving the active-low read/write strobes of every bus register.
module control_sequencer #(
    parameter bit HALT_ON_UNDEFINED = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_step_en,
    input  logic [3:0] i_opcode,
    input  logic       i_flag_carry,
    input  logic       i_flag_zero,
    output logic       o_pc_read_n,
    output logic       o_pc_write_n,
    output logic       o_pc_inc,
    output logic       o_mar_write_n,
    output logic       o_ram_read_n,
    output logic       o_ram_write_n,
    output logic       o_ir_read_n,
    output logic       o_ir_write_n,
    output logic       o_a_read_n,
    output logic       o_a_write_n,
    output logic       o_b_write_n,
    output logic       o_alu_read_n,
    output logic       o_alu_sub,
    output logic       o_flags_write_n,
    output logic       o_out_write_n,
    output logic [2:0] o_step,
    output logic       o_halted
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    step_t step;
    step_t step_next;
    logic  halted;
    logic  halted_next;

    logic  strobe_en;
    logic  undefined_op;
    logic  halt_op;
    logic  last_step;

    logic  pc_read;
    logic  pc_write;
    logic  pc_inc;
    logic  mar_write;
    logic  ram_read;
    logic  ram_write;
    logic  ir_read;
    logic  ir_write;
    logic  a_read;
    logic  a_write;
    logic  b_write;
    logic  alu_read;
    logic  alu_sub;
    logic  flags_write;
    logic  out_write;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            step   <= T0;
            halted <= 1'b0;
        end else begin
            step   <= step_next;
            halted <= halted_next;
        end
    end

    assign undefined_op = (i_opcode >= 4'h9) && (i_opcode <= 4'hD);
    assign halt_op      = (i_opcode == OP_HLT) || (undefined_op && HALT_ON_UNDEFINED);
    assign strobe_en    = i_reset_n && i_step_en && !halted;

    // Only the multi-cycle execute opcodes run past T2; ADD/SUB alone reach T4.
    always_comb begin
        last_step = 1'b1;
        case (step)
            T0, T1: last_step = 1'b0;
            T2: last_step = !((i_opcode == OP_LDA) || (i_opcode == OP_ADD) ||
                              (i_opcode == OP_SUB) || (i_opcode == OP_STA));
            T3: last_step = !((i_opcode == OP_ADD) || (i_opcode == OP_SUB));
            default: last_step = 1'b1;
        endcase
    end

    always_comb begin
        step_next   = step;
        halted_next = halted;
        if (halted) begin
            step_next = T0;
        end else if (i_step_en) begin
            if (last_step) begin
                step_next = T0;
            end else begin
                step_next = step_t'(step + 3'd1);
            end
            if ((step == T2) && halt_op) begin
                halted_next = 1'b1;
            end
        end
    end

    always_comb begin
        pc_read     = 1'b0;
        pc_write    = 1'b0;
        pc_inc      = 1'b0;
        mar_write   = 1'b0;
        ram_read    = 1'b0;
        ram_write   = 1'b0;
        ir_read     = 1'b0;
        ir_write    = 1'b0;
        a_read      = 1'b0;
        a_write     = 1'b0;
        b_write     = 1'b0;
        alu_read    = 1'b0;
        alu_sub     = 1'b0;
        flags_write = 1'b0;
        out_write   = 1'b0;
        if (strobe_en) begin
            case (step)
                T0: begin
                    pc_read   = 1'b1;
                    mar_write = 1'b1;
                end
                T1: begin
                    ram_read = 1'b1;
                    ir_write = 1'b1;
                    pc_inc   = 1'b1;
                end
                T2: begin
                    case (i_opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_read   = 1'b1;
                            mar_write = 1'b1;
                        end
                        OP_LDI: begin
                            ir_read = 1'b1;
                            a_write = 1'b1;
                        end
                        OP_JMP: begin
                            ir_read  = 1'b1;
                            pc_write = 1'b1;
                        end
                        OP_JC: begin
                            ir_read  = i_flag_carry;
                            pc_write = i_flag_carry;
                        end
                        OP_JZ: begin
                            ir_read  = i_flag_zero;
                            pc_write = i_flag_zero;
                        end
                        OP_OUT: begin
                            a_read    = 1'b1;
                            out_write = 1'b1;
                        end
                        default: begin
                            // NOP, HLT and undefined opcodes are silent in T2.
                        end
                    endcase
                end
                T3: begin
                    case (i_opcode)
                        OP_LDA: begin
                            ram_read = 1'b1;
                            a_write  = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_read = 1'b1;
                            b_write  = 1'b1;
                            alu_sub  = (i_opcode == OP_SUB);
                        end
                        OP_STA: begin
                            a_read    = 1'b1;
                            ram_write = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                T4: begin
                    if ((i_opcode == OP_ADD) || (i_opcode == OP_SUB)) begin
                        alu_read    = 1'b1;
                        a_write     = 1'b1;
                        flags_write = 1'b1;
                        alu_sub     = (i_opcode == OP_SUB);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_pc_read_n     = ~pc_read;
    assign o_pc_write_n    = ~pc_write;
    assign o_pc_inc        = pc_inc;
    assign o_mar_write_n   = ~mar_write;
    assign o_ram_read_n    = ~ram_read;
    assign o_ram_write_n   = ~ram_write;
    assign o_ir_read_n     = ~ir_read;
    assign o_ir_write_n    = ~ir_write;
    assign o_a_read_n      = ~a_read;
    assign o_a_write_n     = ~a_write;
    assign o_b_write_n     = ~b_write;
    assign o_alu_read_n    = ~alu_read;
    assign o_alu_sub       = alu_sub;
    assign o_flags_write_n = ~flags_write;
    assign o_out_write_n   = ~out_write;
    assign o_step          = step;
    assign o_halted        = halted;

    // OP_NOP is decoded implicitly through the default arms.
    logic unused_nop;
    assign unused_nop = (OP_NOP == 4'h0);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: two instances (undefined opcodes as NOP / as HLT)
// share stimulus; expected per-cycle strobes, step and halt state are queued and checked.
module tb_control_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       step_en;
    logic [3:0] opcode;
    logic       fc;
    logic       fz;

    logic       pr0, pw0, pi0, mw0, rr0, rw0, ir0, iw0, ar0, aw0, bw0, lr0, su0, fw0, ow0, h0;
    logic [2:0] st0;
    logic       pr1, pw1, pi1, mw1, rr1, rw1, ir1, iw1, ar1, aw1, bw1, lr1, su1, fw1, ow1, h1;
    logic [2:0] st1;

    control_sequencer #(.HALT_ON_UNDEFINED(1'b0)) dut0 (
        .i_clk(clk), .i_reset_n(reset_n), .i_step_en(step_en), .i_opcode(opcode),
        .i_flag_carry(fc), .i_flag_zero(fz),
        .o_pc_read_n(pr0), .o_pc_write_n(pw0), .o_pc_inc(pi0), .o_mar_write_n(mw0),
        .o_ram_read_n(rr0), .o_ram_write_n(rw0), .o_ir_read_n(ir0), .o_ir_write_n(iw0),
        .o_a_read_n(ar0), .o_a_write_n(aw0), .o_b_write_n(bw0), .o_alu_read_n(lr0),
        .o_alu_sub(su0), .o_flags_write_n(fw0), .o_out_write_n(ow0),
        .o_step(st0), .o_halted(h0)
    );

    control_sequencer #(.HALT_ON_UNDEFINED(1'b1)) dut1 (
        .i_clk(clk), .i_reset_n(reset_n), .i_step_en(step_en), .i_opcode(opcode),
        .i_flag_carry(fc), .i_flag_zero(fz),
        .o_pc_read_n(pr1), .o_pc_write_n(pw1), .o_pc_inc(pi1), .o_mar_write_n(mw1),
        .o_ram_read_n(rr1), .o_ram_write_n(rw1), .o_ir_read_n(ir1), .o_ir_write_n(iw1),
        .o_a_read_n(ar1), .o_a_write_n(aw1), .o_b_write_n(bw1), .o_alu_read_n(lr1),
        .o_alu_sub(su1), .o_flags_write_n(fw1), .o_out_write_n(ow1),
        .o_step(st1), .o_halted(h1)
    );

    logic [14:0] vec0;
    logic [14:0] vec1;
    assign vec0 = {pr0, pw0, pi0, mw0, rr0, rw0, ir0, iw0, ar0, aw0, bw0, lr0, su0, fw0, ow0};
    assign vec1 = {pr1, pw1, pi1, mw1, rr1, rw1, ir1, iw1, ar1, aw1, bw1, lr1, su1, fw1, ow1};

    localparam logic [14:0] PCR  = 15'h4000;
    localparam logic [14:0] PCW  = 15'h2000;
    localparam logic [14:0] PCI  = 15'h1000;
    localparam logic [14:0] MARW = 15'h0800;
    localparam logic [14:0] RAMR = 15'h0400;
    localparam logic [14:0] RAMW = 15'h0200;
    localparam logic [14:0] IRR  = 15'h0100;
    localparam logic [14:0] IRW  = 15'h0080;
    localparam logic [14:0] AR   = 15'h0040;
    localparam logic [14:0] AW   = 15'h0020;
    localparam logic [14:0] BW   = 15'h0010;
    localparam logic [14:0] ALUR = 15'h0008;
    localparam logic [14:0] SUB  = 15'h0004;
    localparam logic [14:0] FLW  = 15'h0002;
    localparam logic [14:0] OUTW = 15'h0001;
    // Inactive level: every _n strobe high, pc_inc and alu_sub low.
    localparam logic [14:0] IDLE = 15'h6FFB;
    localparam logic [14:0] F0   = PCR | MARW;
    localparam logic [14:0] F1   = RAMR | IRW | PCI;

    typedef struct {
        logic [14:0] s0;
        logic [2:0]  t0;
        logic        e0;
        logic [14:0] s1;
        logic [2:0]  t1;
        logic        e1;
        string       nm;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   tests  = 0;
    int   failed = 0;

    task automatic cyc(input logic rn, input logic en, input logic [3:0] op, input logic c,
                       input logic z, input logic [14:0] m0, input logic [2:0] t0, input logic x0,
                       input logic [14:0] m1, input logic [2:0] t1, input logic x1,
                       input string nm);
        exp_t n;
        @(posedge clk);
        #1;
        reset_n = rn;
        step_en = en;
        opcode  = op;
        fc      = c;
        fz      = z;
        n.s0 = IDLE ^ m0; n.t0 = t0; n.e0 = x0;
        n.s1 = IDLE ^ m1; n.t1 = t1; n.e1 = x1;
        n.nm = nm;
        q.push_back(n);
    endtask

    task automatic cyc2(input logic rn, input logic en, input logic [3:0] op, input logic c,
                        input logic z, input logic [14:0] m, input logic [2:0] t,
                        input logic x, input string nm);
        cyc(rn, en, op, c, z, m, t, x, m, t, x, nm);
    endtask

    task automatic run_op(input logic [3:0] op, input logic c, input logic z, input string nm);
        cyc2(1, 1, op, c, z, F0, 3'd0, 0, {nm, "_t0"});
        cyc2(1, 1, op, c, z, F1, 3'd1, 0, {nm, "_t1"});
        case (op)
            4'h1: begin
                cyc2(1, 1, op, c, z, IRR | MARW, 3'd2, 0, {nm, "_t2"});
                cyc2(1, 1, op, c, z, RAMR | AW, 3'd3, 0, {nm, "_t3"});
            end
            4'h2: begin
                cyc2(1, 1, op, c, z, IRR | MARW, 3'd2, 0, {nm, "_t2"});
                cyc2(1, 1, op, c, z, RAMR | BW, 3'd3, 0, {nm, "_t3"});
                cyc2(1, 1, op, c, z, ALUR | AW | FLW, 3'd4, 0, {nm, "_t4"});
            end
            4'h3: begin
                cyc2(1, 1, op, c, z, IRR | MARW, 3'd2, 0, {nm, "_t2"});
                cyc2(1, 1, op, c, z, RAMR | BW | SUB, 3'd3, 0, {nm, "_t3"});
                cyc2(1, 1, op, c, z, ALUR | AW | FLW | SUB, 3'd4, 0, {nm, "_t4"});
            end
            4'h4: begin
                cyc2(1, 1, op, c, z, IRR | MARW, 3'd2, 0, {nm, "_t2"});
                cyc2(1, 1, op, c, z, AR | RAMW, 3'd3, 0, {nm, "_t3"});
            end
            4'h5: cyc2(1, 1, op, c, z, IRR | AW, 3'd2, 0, {nm, "_t2"});
            4'h6: cyc2(1, 1, op, c, z, IRR | PCW, 3'd2, 0, {nm, "_t2"});
            4'h7: cyc2(1, 1, op, c, z, c ? (IRR | PCW) : 15'h0, 3'd2, 0, {nm, "_t2"});
            4'h8: cyc2(1, 1, op, c, z, z ? (IRR | PCW) : 15'h0, 3'd2, 0, {nm, "_t2"});
            4'hE: cyc2(1, 1, op, c, z, AR | OUTW, 3'd2, 0, {nm, "_t2"});
            default: cyc2(1, 1, op, c, z, 15'h0, 3'd2, 0, {nm, "_t2"});
        endcase
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if (vec0 !== e.s0 || st0 !== e.t0 || h0 !== e.e0) begin
                failed++;
                $display("FAIL %s nop_dut strobes=%h step=%0d halted=%b required strobes=%h step=%0d halted=%b",
                         e.nm, vec0, st0, h0, e.s0, e.t0, e.e0);
            end
            tests++;
            if (vec1 !== e.s1 || st1 !== e.t1 || h1 !== e.e1) begin
                failed++;
                $display("FAIL %s hlt_dut strobes=%h step=%0d halted=%b required strobes=%h step=%0d halted=%b",
                         e.nm, vec1, st1, h1, e.s1, e.t1, e.e1);
            end
            tests++;
            if ($countones(~{pr0, rr0, ir0, ar0, lr0}) > 1 ||
                (!pr0 && !pw0) || (!rr0 && !rw0) || (!ir0 && !iw0) || (!ar0 && !aw0)) begin
                failed++;
                $display("FAIL %s bus_conflict reads_n=%b required at most one low, no read+write pair",
                         e.nm, {pr0, rr0, ir0, ar0, lr0});
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    logic [3:0] ops [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hE};

    initial begin
        reset_n = 1'b0;
        step_en = 1'b0;
        opcode  = 4'h0;
        fc      = 1'b0;
        fz      = 1'b0;

        cyc2(0, 1, 4'h0, 0, 0, 15'h0, 3'd0, 0, "reset_a");
        cyc2(0, 1, 4'h0, 0, 0, 15'h0, 3'd0, 0, "reset_b");

        run_op(4'h1, 0, 0, "lda");
        run_op(4'h2, 0, 0, "add");
        run_op(4'h3, 0, 0, "sub");
        run_op(4'h7, 0, 0, "jc_nc");
        run_op(4'h7, 1, 0, "jc_c");
        run_op(4'h8, 1, 0, "jz_nz");
        run_op(4'h8, 0, 1, "jz_z");
        run_op(4'h0, 0, 0, "nop");
        run_op(4'h5, 0, 0, "ldi");
        run_op(4'h6, 0, 0, "jmp");
        run_op(4'hE, 0, 0, "out");
        run_op(4'h4, 0, 0, "sta");

        // ADD frozen for three cycles in T3, then resumes at T3.
        cyc2(1, 1, 4'h2, 0, 0, F0, 3'd0, 0, "stall_t0");
        cyc2(1, 1, 4'h2, 0, 0, F1, 3'd1, 0, "stall_t1");
        cyc2(1, 1, 4'h2, 0, 0, IRR | MARW, 3'd2, 0, "stall_t2");
        for (int i = 0; i < 3; i++) cyc2(1, 0, 4'h2, 0, 0, 15'h0, 3'd3, 0, "stall_hold");
        cyc2(1, 1, 4'h2, 0, 0, RAMR | BW, 3'd3, 0, "stall_resume_t3");
        cyc2(1, 1, 4'h2, 0, 0, ALUR | AW | FLW, 3'd4, 0, "stall_t4");

        // Reset lands in STA T3: no RAM write during the reset cycle.
        cyc2(1, 1, 4'h4, 0, 0, F0, 3'd0, 0, "starst_t0");
        cyc2(1, 1, 4'h4, 0, 0, F1, 3'd1, 0, "starst_t1");
        cyc2(1, 1, 4'h4, 0, 0, IRR | MARW, 3'd2, 0, "starst_t2");
        cyc2(0, 1, 4'h4, 0, 0, 15'h0, 3'd3, 0, "starst_rst");
        run_op(4'h0, 0, 0, "after_rst");

        cyc2(1, 1, 4'hF, 0, 0, F0, 3'd0, 0, "hlt_t0");
        cyc2(1, 1, 4'hF, 0, 0, F1, 3'd1, 0, "hlt_t1");
        cyc2(1, 1, 4'hF, 0, 0, 15'h0, 3'd2, 0, "hlt_t2");
        for (int i = 0; i < 20; i++) cyc2(1, i[0], 4'hF, 0, 0, 15'h0, 3'd0, 1, "halted");
        cyc2(0, 1, 4'hF, 0, 0, 15'h0, 3'd0, 1, "halt_rst");
        run_op(4'h0, 0, 0, "post_halt");

        for (int i = 0; i < 25; i++) begin
            run_op(ops[$urandom_range(0, 9)], 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), "sweep");
        end

        // Undefined opcodes: 3-cycle NOP on one instance, halt on the other.
        for (int op = 9; op <= 13; op++) begin
            cyc2(1, 1, 4'(op), 0, 0, F0, 3'd0, 0, "undef_t0");
            cyc2(1, 1, 4'(op), 0, 0, F1, 3'd1, 0, "undef_t1");
            cyc2(1, 1, 4'(op), 0, 0, 15'h0, 3'd2, 0, "undef_t2");
            cyc(0, 1, 4'(op), 0, 0, 15'h0, 3'd0, 0, 15'h0, 3'd0, 1, "undef_end");
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        tests++;
        if (q.size() != 0) begin
            failed++;
            $display("FAIL drain pending=%0d required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
